register_pipe: RTL and testbench
================================

Name: register_pipe

Overview:
- Parametrised successor to the fixed 10-bit register: a DEPTH-stage, WIDTH-bit elastic pipeline register with valid/ready handshaking on both sides.
- Adds a per-stage valid bit, backpressure, bubble collapse, synchronous flush and an occupancy count.
- Sits between datapath blocks that need registered, stallable delay with guaranteed ordering and no data loss.

Parameters:
- WIDTH, 10, data bits per stage (must be >= 1).
- DEPTH, 4, number of register stages (must be >= 1).
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  upstream data.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  block accepts in_data this cycle.
- out_data  output  WIDTH  data held in the last stage.
- out_valid  output  1  last stage holds valid data.
- out_ready  input  1  downstream accepts out_data this cycle.
- flush  input  1  synchronous clear of all stages.
- count  output  CNT_W  number of valid stages, 0..DEPTH.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n, clk). While rst_n=0, all stage valid bits=0, all stage data=0, out_valid=0, out_data=0 and count=0, immediately and independent of clk. in_ready=1 when rst_n=1, flush=0 and the pipe is empty.
- Stages 0..DEPTH-1 each hold {valid_i, data_i}. Stage 0 is the input side; stage DEPTH-1 drives out_valid and out_data.
- Ready chain (combinational): rdy_DEPTH = out_ready; rdy_i = !valid_i | rdy_{i+1}; in_ready = rdy_0 & !flush.
- Transfers: input accepted when in_valid & in_ready; output popped when out_valid & out_ready.
- On clk when rdy_i=1: stage i loads {valid, data} from stage i-1, or from the input for stage 0 (valid = in_valid & in_ready). When rdy_i=0, stage i holds.
- Data registers load only on a valid transfer. A stage that becomes empty keeps its stale data, so out_data is don't-care while out_valid=0.
- Latency: with the pipe empty and out_ready=1, a word accepted at edge N is presented on out_valid/out_data after edge N+DEPTH-1, i.e. DEPTH cycles of register delay. Throughput is 1 word/cycle with no bubbles when out_ready stays high.
- Bubble collapse: when out_ready=0, empty stages still advance, so valid words compact toward the output. Full when all DEPTH valid bits are 1; then in_ready = out_ready.
- count: next = count + accept - pop. Simultaneous accept and pop leave count unchanged. count never exceeds DEPTH and never goes below 0.
- Full with out_ready=1 and in_valid=1: pop and accept happen on the same edge and count stays at DEPTH.
- Empty with out_ready=1: out_valid stays 0 and count stays 0.
- flush=1 on an edge clears every valid bit and sets count=0. No input is accepted that cycle (in_ready=0). out_valid may be 1 in the flush cycle, but a pop in that cycle does not matter because everything is cleared. Data registers are left unchanged.
- rst_n asserted mid-stream discards all contents. The first accept after rst_n deasserts starts from the empty state.
- Ordering: words exit in acceptance order. No duplication and no loss except by flush or reset.

Test Plan:
- Reset (WIDTH=10, DEPTH=4): rst_n=0 -> out_valid=0, out_data=0, count=0. After release with flush=0 -> in_ready=1.
- Streaming: out_ready=1, in_valid=1, in_data=0..62 one per cycle -> word 0 appears 4 cycles after acceptance, then 1..62 on consecutive cycles with no gaps; count holds at 4 during the steady stream.
- Backpressure: out_ready=0, push 1023,1,2,3,4 -> first four accepted, in_ready=0 with 4 pending, count=4. Raise out_ready -> outputs 1023,1,2,3, then 4 in order.
- Bubble collapse: out_ready=0, push 5, idle 2 cycles, push 6 -> both reach stages 3/2 adjacent, count=2. Raise out_ready -> 5 then 6 on back-to-back cycles.
- Flush: pipe holding 7,8,9, flush=1 with in_valid=1, in_data=10 -> next cycle count=0 and out_valid=0; 10 is not accepted.
- Async reset mid-stream: drop rst_n between clock edges with count=3 -> out_valid and count go to 0 before the next edge.

Source files
------------

// File: rtl/register_pipe.sv
// Elastic DEPTH-stage, WIDTH-bit pipeline register with valid/ready handshaking.
// Empty stages keep advancing under backpressure, so stalled words compact toward the output.
module register_pipe #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             flush,
    output logic [CNT_W-1:0] count
);

    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [DEPTH:0]   rdy;
    logic             tail_full;
    logic             accept;
    logic             pop;

    // A stage can load when any stage at or beyond it is empty, or the output drains.
    // Equivalent to the rdy_i = !valid_i | rdy_{i+1} chain without a self-referencing vector.
    always_comb begin
        tail_full  = 1'b1;
        rdy        = '0;
        rdy[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            tail_full = tail_full & valid_q[i];
            rdy[i]    = out_ready | ~tail_full;
        end
    end

    assign in_ready  = rdy[0] & ~flush;
    assign accept    = in_valid & in_ready;
    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign pop       = out_valid & out_ready;
    assign count     = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else if (flush) begin
            valid_q <= '0;
            count_q <= '0;
        end else begin
            if (rdy[0]) begin
                valid_q[0] <= accept;
                if (accept) begin
                    data_q[0] <= in_data;
                end
            end
            // Data only moves with a valid word; emptied stages keep stale data.
            for (int i = 1; i < DEPTH; i++) begin
                if (rdy[i]) begin
                    valid_q[i] <= valid_q[i-1];
                    if (valid_q[i-1]) begin
                        data_q[i] <= data_q[i-1];
                    end
                end
            end
            count_q <= count_q + CNT_W'(accept) - CNT_W'(pop);
        end
    end

endmodule

// File: tb/tb_register_pipe.sv
// Self-checking bench for register_pipe: directed scenarios plus random traffic
// compared against a queue-based model of words travelling along a DEPTH-slot road.
module tb_register_pipe;

    localparam int WIDTH = 10;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             flush;
    logic [CNT_W-1:0] count;

    int num_checks = 0;
    int num_errors = 0;

    // Model: one entry per word in the pipe, head first, with its stage position.
    int q_data[$];
    int q_pos[$];

    register_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .flush(flush),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // One cycle: drive after the falling edge, check before the rising edge, then advance the model.
    task automatic applyStimulus(input logic iv, input logic [WIDTH-1:0] d, input logic ordy, input logic fl);
        logic exp_valid;
        logic exp_ready;
        logic acc;
        logic pop;
        int   lim;
        int   nxt;
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
        exp_valid = (q_pos.size() > 0) && (q_pos[0] == DEPTH - 1);
        exp_ready = !fl && ((q_pos.size() < DEPTH) || ordy);
        checkOutput("out_valid", 32'(out_valid), 32'(exp_valid));
        if (exp_valid) begin
            checkOutput("out_data", 32'(out_data), q_data[0]);
        end
        checkOutput("count", 32'(count), q_pos.size());
        checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
        acc = iv && exp_ready;
        pop = exp_valid && ordy;
        @(posedge clk);
        if (fl) begin
            q_data.delete();
            q_pos.delete();
        end else begin
            if (pop) begin
                void'(q_data.pop_front());
                void'(q_pos.pop_front());
            end
            // Each word moves one step unless it would run into the word ahead of it.
            for (int k = 0; k < q_pos.size(); k++) begin
                lim = (k == 0) ? DEPTH - 1 : q_pos[k-1] - 1;
                nxt = q_pos[k] + 1;
                q_pos[k] = (nxt < lim) ? nxt : lim;
            end
            if (acc) begin
                q_data.push_back(int'(d));
                q_pos.push_back(0);
            end
        end
    endtask

    // Asserts reset between clock edges and checks the outputs clear before the next edge.
    task automatic asyncReset();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_count", 32'(count), 32'd0);
        q_data.delete();
        q_pos.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic             r_iv;
        logic             r_ordy;
        logic             r_fl;
        logic [WIDTH-1:0] r_d;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;

        // Power-on reset
        asyncReset();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Streaming 0..62 at full throughput, then drain
        for (int i = 0; i < 63; i++) begin
            applyStimulus(1'b1, WIDTH'(i), 1'b1, 1'b0);
        end
        for (int i = 0; i < DEPTH + 1; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
        end

        // Backpressure: fill, reject the fifth word, then release with simultaneous push/pop
        applyStimulus(1'b1, 10'd1023, 1'b0, 1'b0);
        applyStimulus(1'b1, 10'd1, 1'b0, 1'b0);
        applyStimulus(1'b1, 10'd2, 1'b0, 1'b0);
        applyStimulus(1'b1, 10'd3, 1'b0, 1'b0);
        applyStimulus(1'b1, 10'd4, 1'b0, 1'b0);
        applyStimulus(1'b1, 10'd4, 1'b0, 1'b0);
        applyStimulus(1'b1, 10'd4, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH + 2; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
        end

        // Bubble collapse
        applyStimulus(1'b1, 10'd5, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b1, 10'd6, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
        end

        // Flush with a competing input word
        applyStimulus(1'b1, 10'd7, 1'b0, 1'b0);
        applyStimulus(1'b1, 10'd8, 1'b0, 1'b0);
        applyStimulus(1'b1, 10'd9, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b1, 10'd10, 1'b1, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Async reset mid-stream with three words held
        applyStimulus(1'b1, 10'd11, 1'b0, 1'b0);
        applyStimulus(1'b1, 10'd12, 1'b0, 1'b0);
        applyStimulus(1'b1, 10'd13, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        asyncReset();
        applyStimulus(1'b1, 10'd14, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH + 1; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
        end

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            r_iv   = ($urandom_range(0, 3) != 0);
            r_ordy = ($urandom_range(0, 2) != 0);
            r_fl   = ($urandom_range(0, 40) == 0);
            r_d    = WIDTH'($urandom_range(0, 1023));
            applyStimulus(r_iv, r_d, r_ordy, r_fl);
        end
        for (int i = 0; i < DEPTH + 2; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
